// File: rtl/morse_digit_ctrl.sv
// Morse key sequencer: times presses on a single key, assembles 5-element
// digit codes and issues non-overlapping commit/backspace strobes.
module morse_digit_ctrl #(
    parameter int DOT_MAX = 4,
    parameter int GAP_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       bksp_key,
    output logic [3:0] sym_val,
    output logic       sym_flag,
    output logic       bksp_out,
    output logic       busy,
    output logic [2:0] elem_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_LEN);
    localparam logic [2:0]       ELEM_MAX = 3'd6;
    localparam logic [2:0]       ELEM_FULL = 3'd5;

    // First element sits in the MSB; dot = 0, dash = 1.
    function automatic logic [3:0] decode_digit(input logic [4:0] code);
        logic [3:0] digit;
        case (code)
            5'b01111: digit = 4'd1;
            5'b00111: digit = 4'd2;
            5'b00011: digit = 4'd3;
            5'b00001: digit = 4'd4;
            5'b00000: digit = 4'd5;
            5'b10000: digit = 4'd6;
            5'b11000: digit = 4'd7;
            5'b11100: digit = 4'd8;
            5'b11110: digit = 4'd9;
            5'b11111: digit = 4'd0;
            default:  digit = 4'hF;
        endcase
        return digit;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] press_cnt_r;
    logic [CNT_W-1:0] press_cnt_nxt_s;
    logic [CNT_W-1:0] gap_cnt_r;
    logic [CNT_W-1:0] gap_cnt_nxt_s;
    logic [4:0]       code_r;
    logic [4:0]       code_nxt_s;
    logic [2:0]       elem_cnt_r;
    logic [2:0]       elem_cnt_nxt_s;
    logic [3:0]       sym_val_r;
    logic [3:0]       sym_val_nxt_s;
    logic             sym_flag_r;
    logic             sym_flag_nxt_s;
    logic             bksp_out_r;
    logic             bksp_out_nxt_s;
    logic             bksp_pend_r;
    logic             bksp_pend_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             key_q_r;
    logic             bksp_q_r;
    logic             key_rise_s;
    logic             key_fall_s;
    logic             bksp_rise_s;
    logic             dash_s;

    assign key_rise_s  = key & ~key_q_r;
    assign key_fall_s  = ~key & key_q_r;
    assign bksp_rise_s = bksp_key & ~bksp_q_r;
    assign dash_s      = (press_cnt_r > DOT_LIM);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, element capture and strobe generation.
    always_comb begin
        state_nxt_s     = state_r;
        press_cnt_nxt_s = press_cnt_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        code_nxt_s      = code_r;
        elem_cnt_nxt_s  = elem_cnt_r;
        sym_val_nxt_s   = sym_val_r;
        sym_flag_nxt_s  = 1'b0;
        bksp_out_nxt_s  = 1'b0;
        bksp_pend_nxt_s = bksp_pend_r;

        case (state_r)
            IDLE: begin
                if (bksp_pend_r || bksp_rise_s) begin
                    bksp_out_nxt_s  = 1'b1;
                    // A fresh press landing with a deferred one stays queued.
                    bksp_pend_nxt_s = bksp_pend_r & bksp_rise_s;
                end else begin
                    bksp_pend_nxt_s = 1'b0;
                end
                if (key_rise_s) begin
                    state_nxt_s     = PRESS;
                    press_cnt_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            PRESS: begin
                if (bksp_rise_s) begin
                    state_nxt_s     = IDLE;
                    press_cnt_nxt_s = CNT_ZERO;
                    gap_cnt_nxt_s   = CNT_ZERO;
                    code_nxt_s      = 5'd0;
                    elem_cnt_nxt_s  = 3'd0;
                end else if (key_fall_s) begin
                    code_nxt_s    = {code_r[3:0], dash_s};
                    gap_cnt_nxt_s = CNT_ONE;
                    state_nxt_s   = GAP;
                    if (elem_cnt_r == ELEM_MAX) begin
                        elem_cnt_nxt_s = ELEM_MAX;
                    end else begin
                        elem_cnt_nxt_s = elem_cnt_r + 3'd1;
                    end
                end else if (key) begin
                    press_cnt_nxt_s = sat_inc(press_cnt_r);
                end else begin
                    press_cnt_nxt_s = press_cnt_r;
                end
            end

            GAP: begin
                // Closing the letter outranks both a new press and a backspace.
                if (gap_cnt_r == GAP_LIM) begin
                    state_nxt_s = EMIT;
                    if (bksp_rise_s) begin
                        bksp_pend_nxt_s = 1'b1;
                    end else begin
                        bksp_pend_nxt_s = bksp_pend_r;
                    end
                end else if (bksp_rise_s) begin
                    state_nxt_s     = IDLE;
                    press_cnt_nxt_s = CNT_ZERO;
                    gap_cnt_nxt_s   = CNT_ZERO;
                    code_nxt_s      = 5'd0;
                    elem_cnt_nxt_s  = 3'd0;
                end else if (key_rise_s) begin
                    state_nxt_s     = PRESS;
                    press_cnt_nxt_s = CNT_ONE;
                end else begin
                    gap_cnt_nxt_s = sat_inc(gap_cnt_r);
                end
            end

            EMIT: begin
                sym_flag_nxt_s = 1'b1;
                if (elem_cnt_r == ELEM_FULL) begin
                    sym_val_nxt_s = decode_digit(code_r);
                end else begin
                    sym_val_nxt_s = 4'hF;
                end
                if (bksp_rise_s) begin
                    bksp_pend_nxt_s = 1'b1;
                end else begin
                    bksp_pend_nxt_s = bksp_pend_r;
                end
                code_nxt_s      = 5'd0;
                elem_cnt_nxt_s  = 3'd0;
                press_cnt_nxt_s = CNT_ZERO;
                gap_cnt_nxt_s   = CNT_ZERO;
                state_nxt_s     = IDLE;
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        busy_nxt_s = (elem_cnt_nxt_s != 3'd0) | key;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_cnt_r <= CNT_ZERO;
            gap_cnt_r   <= CNT_ZERO;
            code_r      <= 5'd0;
            elem_cnt_r  <= 3'd0;
            sym_val_r   <= 4'd0;
            sym_flag_r  <= 1'b0;
            bksp_out_r  <= 1'b0;
            bksp_pend_r <= 1'b0;
            busy_r      <= 1'b0;
            key_q_r     <= 1'b0;
            bksp_q_r    <= 1'b0;
        end else begin
            press_cnt_r <= press_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            code_r      <= code_nxt_s;
            elem_cnt_r  <= elem_cnt_nxt_s;
            sym_val_r   <= sym_val_nxt_s;
            sym_flag_r  <= sym_flag_nxt_s;
            bksp_out_r  <= bksp_out_nxt_s;
            bksp_pend_r <= bksp_pend_nxt_s;
            busy_r      <= busy_nxt_s;
            key_q_r     <= key;
            bksp_q_r    <= bksp_key;
        end
    end

    assign sym_val  = sym_val_r;
    assign sym_flag = sym_flag_r;
    assign bksp_out = bksp_out_r;
    assign busy     = busy_r;
    assign elem_cnt = elem_cnt_r;

endmodule

// File: tb/tb_morse_digit_ctrl.sv
// Directed bench for morse_digit_ctrl: digits, invalid codes, timing
// boundaries, backspace handling and commit/backspace collisions.
module tb_morse_digit_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key = 1'b0;
    logic       bksp_key = 1'b0;
    logic [3:0] sym_val;
    logic       sym_flag;
    logic       bksp_out;
    logic       busy;
    logic [2:0] elem_cnt;

    int checks = 0;
    int errors = 0;
    int flag_cnt = 0;
    int bksp_cnt = 0;
    int overlap_cnt = 0;

    morse_digit_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .bksp_key (bksp_key),
        .sym_val  (sym_val),
        .sym_flag (sym_flag),
        .bksp_out (bksp_out),
        .busy     (busy),
        .elem_cnt (elem_cnt)
    );

    always #5 clk = ~clk;

    // Strobe pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (sym_flag === 1'b1) flag_cnt++;
        if (bksp_out === 1'b1) bksp_cnt++;
        if (sym_flag === 1'b1 && bksp_out === 1'b1) overlap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        key = 1'b1;
        repeat (n) tick();
        key = 1'b0;
    endtask

    // Elements are taken MSB-first from the low nel bits of code.
    task automatic send_letter(input logic [5:0] code, input int nel,
                               input int dot_len, input int dash_len, input int gap_len);
        for (int i = 0; i < nel; i++) begin
            press(code[nel-1-i] ? dash_len : dot_len);
            if (i != nel - 1) repeat (gap_len) tick();
        end
    endtask

    task automatic wait_flag(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sym_flag === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key = ~key;
            tick();
        end
        checks++; if (sym_val !== 4'd0) begin errors++; $display("FAIL rst_sym_val got %h exp 0", sym_val); end
        checks++; if (sym_flag !== 1'b0 || bksp_out !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b exp 00", sym_flag, bksp_out); end
        checks++; if (elem_cnt !== 3'd0) begin errors++; $display("FAIL rst_elem_cnt got %0d exp 0", elem_cnt); end
        key = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0 || elem_cnt !== 3'd0 || sym_flag !== 1'b0) begin
            errors++; $display("FAIL rst_release got busy=%b elem=%0d flag=%b exp 0/0/0", busy, elem_cnt, sym_flag);
        end
    endtask

    task automatic test_digits();
        int lat;
        int f0;
        f0 = flag_cnt;
        send_letter(6'b001111, 5, 2, 6, 3);
        tick();
        checks++; if (elem_cnt !== 3'd5 || busy !== 1'b1) begin errors++; $display("FAIL d1_elem got %0d busy=%b exp 5 busy=1", elem_cnt, busy); end
        wait_flag(lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL d1_latency got %0d exp 9", lat); end
        checks++; if (sym_val !== 4'd1) begin errors++; $display("FAIL d1_val got %h exp 1", sym_val); end
        tick();
        checks++; if (sym_flag !== 1'b0 || sym_val !== 4'd1 || elem_cnt !== 3'd0) begin
            errors++; $display("FAIL d1_after got flag=%b val=%h elem=%0d exp 0/1/0", sym_flag, sym_val, elem_cnt);
        end
        checks++; if (flag_cnt - f0 != 1) begin errors++; $display("FAIL d1_pulses got %0d exp 1", flag_cnt - f0); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d1_busy got %b exp 0", busy); end

        send_letter(6'b011111, 5, 2, 6, 3);
        tick();
        wait_flag(lat);
        checks++; if (lat != 9 || sym_val !== 4'd0) begin errors++; $display("FAIL d0 got lat=%0d val=%h exp 9/0", lat, sym_val); end
        repeat (3) tick();
    endtask

    task automatic test_invalid();
        int lat;
        send_letter(6'b000000, 3, 2, 6, 3);
        tick();
        checks++; if (elem_cnt !== 3'd3) begin errors++; $display("FAIL inv3_elem got %0d exp 3", elem_cnt); end
        wait_flag(lat);
        checks++; if (lat != 9 || sym_val !== 4'hF) begin errors++; $display("FAIL inv3 got lat=%0d val=%h exp 9/F", lat, sym_val); end
        repeat (3) tick();

        send_letter(6'b000000, 6, 2, 6, 3);
        tick();
        checks++; if (elem_cnt !== 3'd6) begin errors++; $display("FAIL inv6_elem got %0d exp 6", elem_cnt); end
        wait_flag(lat);
        checks++; if (lat != 9 || sym_val !== 4'hF) begin errors++; $display("FAIL inv6 got lat=%0d val=%h exp 9/F", lat, sym_val); end
        repeat (3) tick();

        send_letter(6'b001010, 5, 2, 6, 3);
        tick();
        wait_flag(lat);
        checks++; if (sym_val !== 4'hF) begin errors++; $display("FAIL inv5 got %h exp F", sym_val); end
        repeat (3) tick();
    endtask

    task automatic test_boundaries();
        int lat;
        // 4-cycle press is a dot, 5-cycle press is a dash.
        send_letter(6'b001111, 5, 4, 5, 3);
        tick();
        wait_flag(lat);
        checks++; if (sym_val !== 4'd1) begin errors++; $display("FAIL len4_dot got %h exp 1", sym_val); end
        repeat (3) tick();
        send_letter(6'b010000, 5, 4, 5, 3);
        tick();
        wait_flag(lat);
        checks++; if (sym_val !== 4'd6) begin errors++; $display("FAIL len5_dash got %h exp 6", sym_val); end
        repeat (3) tick();

        send_letter(6'b000011, 5, 2, 6, 7);
        tick();
        wait_flag(lat);
        checks++; if (lat != 9 || sym_val !== 4'd3) begin errors++; $display("FAIL gap7_open got lat=%0d val=%h exp 9/3", lat, sym_val); end
        repeat (3) tick();

        press(2);
        repeat (8) tick();
        key = 1'b1;
        tick();
        key = 1'b0;
        tick();
        checks++; if (sym_flag !== 1'b1 || sym_val !== 4'hF) begin errors++; $display("FAIL gap8_close got flag=%b val=%h exp 1/F", sym_flag, sym_val); end
        tick();
        checks++; if (sym_flag !== 1'b0 || elem_cnt !== 3'd0) begin errors++; $display("FAIL gap8_after got flag=%b elem=%0d exp 0/0", sym_flag, elem_cnt); end
        repeat (3) tick();
    endtask

    task automatic test_backspace();
        int lat;
        int f0;
        int b0;
        f0 = flag_cnt;
        b0 = bksp_cnt;
        bksp_key = 1'b1;
        tick();
        checks++; if (bksp_out !== 1'b1 || sym_flag !== 1'b0) begin errors++; $display("FAIL bk_idle got bksp=%b flag=%b exp 1/0", bksp_out, sym_flag); end
        tick();
        checks++; if (bksp_out !== 1'b0) begin errors++; $display("FAIL bk_idle_width got %b exp 0", bksp_out); end
        bksp_key = 1'b0;
        repeat (2) tick();

        send_letter(6'b000010, 2, 2, 6, 3);
        tick();
        checks++; if (elem_cnt !== 3'd2) begin errors++; $display("FAIL bk_part_elem got %0d exp 2", elem_cnt); end
        tick();
        bksp_key = 1'b1;
        tick();
        checks++; if (elem_cnt !== 3'd0 || busy !== 1'b0 || bksp_out !== 1'b0) begin
            errors++; $display("FAIL bk_discard got elem=%0d busy=%b bksp=%b exp 0/0/0", elem_cnt, busy, bksp_out);
        end
        bksp_key = 1'b0;
        repeat (15) tick();
        checks++; if (flag_cnt - f0 != 0 || bksp_cnt - b0 != 1) begin
            errors++; $display("FAIL bk_pulses got flags=%0d bksp=%0d exp 0/1", flag_cnt - f0, bksp_cnt - b0);
        end
        send_letter(6'b000001, 5, 2, 6, 3);
        tick();
        wait_flag(lat);
        checks++; if (lat != 9 || sym_val !== 4'd4) begin errors++; $display("FAIL bk_next got lat=%0d val=%h exp 9/4", lat, sym_val); end
        repeat (3) tick();
    endtask

    task automatic test_collision();
        // Backspace rising in the EMIT cycle.
        send_letter(6'b000000, 5, 2, 6, 3);
        tick();
        repeat (8) tick();
        bksp_key = 1'b1;
        tick();
        checks++; if (sym_flag !== 1'b1 || sym_val !== 4'd5 || bksp_out !== 1'b0) begin
            errors++; $display("FAIL col_emit_n got flag=%b val=%h bksp=%b exp 1/5/0", sym_flag, sym_val, bksp_out);
        end
        tick();
        checks++; if (sym_flag !== 1'b0 || bksp_out !== 1'b1) begin errors++; $display("FAIL col_emit_n1 got flag=%b bksp=%b exp 0/1", sym_flag, bksp_out); end
        tick();
        checks++; if (bksp_out !== 1'b0) begin errors++; $display("FAIL col_emit_n2 got %b exp 0", bksp_out); end
        bksp_key = 1'b0;
        repeat (3) tick();

        // Backspace rising in the cycle GAP hands over to EMIT.
        send_letter(6'b011110, 5, 2, 6, 3);
        tick();
        repeat (7) tick();
        bksp_key = 1'b1;
        tick();
        checks++; if (bksp_out !== 1'b0 || sym_flag !== 1'b0) begin errors++; $display("FAIL col_gap_n0 got flag=%b bksp=%b exp 0/0", sym_flag, bksp_out); end
        tick();
        checks++; if (sym_flag !== 1'b1 || sym_val !== 4'd9 || bksp_out !== 1'b0) begin
            errors++; $display("FAIL col_gap_n got flag=%b val=%h bksp=%b exp 1/9/0", sym_flag, sym_val, bksp_out);
        end
        tick();
        checks++; if (sym_flag !== 1'b0 || bksp_out !== 1'b1) begin errors++; $display("FAIL col_gap_n1 got flag=%b bksp=%b exp 0/1", sym_flag, bksp_out); end
        bksp_key = 1'b0;
        repeat (3) tick();
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL overlap got %0d exp 0", overlap_cnt); end
    endtask

    task automatic test_reset_mid();
        int f0;
        send_letter(6'b000011, 3, 2, 6, 3);
        tick();
        rst = 1'b0;
        #1;
        checks++; if (elem_cnt !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid got elem=%0d busy=%b exp 0/0", elem_cnt, busy); end
        f0 = flag_cnt;
        tick();
        rst = 1'b1;
        repeat (15) tick();
        checks++; if (flag_cnt - f0 != 0 || sym_val !== 4'd0) begin
            errors++; $display("FAIL rstmid_quiet got flags=%0d val=%h exp 0/0", flag_cnt - f0, sym_val);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_invalid();
        test_boundaries();
        test_backspace();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
